// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR block: addresses, array indices,
// operation encoding, mstatus field positions and WARL write masks.
package csr_pkg;

  localparam int unsigned XLEN = 64;

  // Writable machine-mode CSRs
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;

  // Read-only CSRs; writes to these are illegal
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;

  localparam int unsigned IDX_MSCRATCH = 0;
  localparam int unsigned IDX_MSTATUS  = 1;
  localparam int unsigned IDX_MCAUSE   = 2;
  localparam int unsigned IDX_MTVEC    = 3;
  localparam int unsigned IDX_MEPC     = 4;
  localparam int unsigned IDX_CYCLE    = 5;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE     = 3;
  localparam int unsigned MSTATUS_MPIE    = 7;
  localparam int unsigned MSTATUS_MPP_LSB = 11;
  localparam logic [1:0]  MSTATUS_MPP_M   = 2'b11;

  localparam logic [XLEN-1:0] MSTATUS_FIXED = XLEN'(MSTATUS_MPP_M) << MSTATUS_MPP_LSB;
  localparam logic [XLEN-1:0] MSTATUS_WMASK = (XLEN'(1) << MSTATUS_MIE) | (XLEN'(1) << MSTATUS_MPIE);
  localparam logic [XLEN-1:0] MEPC_WMASK    = ~XLEN'(3);
  localparam logic [XLEN-1:0] MTVEC_WMASK   = ~XLEN'(2);

endpackage

// File: rtl/csr_alu.sv
// Combinational RW/RS/RC merge of a CSR's current value with the write data,
// plus the flag that suppresses the write (no-op, or RS/RC with zero data).
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  csr_op_e        op,
  input  logic [N-1:0]   old_val,
  input  logic [N-1:0]   wdata,
  output logic [N-1:0]   wval_c,
  output logic           suppress_c
);

  always_comb begin
    wval_c     = old_val;
    suppress_c = 1'b0;
    case (op)
      CSR_RW: wval_c = wdata;
      CSR_RS: begin
        wval_c     = old_val | wdata;
        suppress_c = (wdata == '0);
      end
      CSR_RC: begin
        wval_c     = old_val & ~wdata;
        suppress_c = (wdata == '0);
      end
      default: suppress_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_regs.sv
// Machine-mode CSR storage and write unit: CSR instruction writes, trap entry,
// MRET and the cycle counter (built only when CSR_CYCLE_EN is defined).
module csr_regs
  import csr_pkg::*;
#(
  parameter int unsigned  N         = 64,
  parameter int unsigned  W_CSR     = 256,
  parameter logic [N-1:0] MTVEC_RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         csr_we,
  input  logic [1:0]   csr_op,
  input  logic [11:0]  csr_addr,
  input  logic [N-1:0] csr_wdata,
  input  logic         trap,
  input  logic [N-1:0] trap_cause,
  input  logic [N-1:0] trap_pc,
  input  logic         mret,
  input  logic         stall,
  output logic [N-1:0] csr_out [0:W_CSR-1],
  output logic         csr_illegal
);

  localparam logic [N-1:0] MSTATUS_RST = N'(MSTATUS_FIXED);
  localparam logic [N-1:0] MTVEC_RSTV  = MTVEC_RST & N'(MTVEC_WMASK);

  logic [N-1:0] mscratch_q, mstatus_q, mcause_q, mtvec_q, mepc_q;

  logic         hit_mscratch, hit_mstatus, hit_mcause, hit_mtvec, hit_mepc;
  logic         writable;
  logic [N-1:0] old_val;
  logic [N-1:0] wval_c;
  logic         suppress_c;
  logic         do_trap, do_mret, do_csr;

  // Address decode and current-value select for the read-modify-write
  always_comb begin
    hit_mscratch = 1'b0;
    hit_mstatus  = 1'b0;
    hit_mcause   = 1'b0;
    hit_mtvec    = 1'b0;
    hit_mepc     = 1'b0;
    old_val      = '0;
    case (csr_addr)
      ADDR_MSCRATCH: begin hit_mscratch = 1'b1; old_val = mscratch_q; end
      ADDR_MSTATUS:  begin hit_mstatus  = 1'b1; old_val = mstatus_q;  end
      ADDR_MCAUSE:   begin hit_mcause   = 1'b1; old_val = mcause_q;   end
      ADDR_MTVEC:    begin hit_mtvec    = 1'b1; old_val = mtvec_q;    end
      ADDR_MEPC:     begin hit_mepc     = 1'b1; old_val = mepc_q;     end
      ADDR_MISA, ADDR_MVENDORID, ADDR_MARCHID,
      ADDR_MIMPID, ADDR_MHARTID, ADDR_CYCLE: old_val = '0;
      default: old_val = '0;
    endcase
  end

  assign writable = hit_mscratch | hit_mstatus | hit_mcause | hit_mtvec | hit_mepc;

  csr_alu #(
    .N (N)
  ) u_alu (
    .op         (csr_op_e'(csr_op)),
    .old_val    (old_val),
    .wdata      (csr_wdata),
    .wval_c     (wval_c),
    .suppress_c (suppress_c)
  );

  // trap beats mret beats a CSR write; stall blocks all three
  assign do_trap = ~stall & trap;
  assign do_mret = ~stall & ~trap & mret;
  assign do_csr  = ~stall & ~trap & ~mret & csr_we & ~suppress_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mscratch_q  <= '0;
      mstatus_q   <= MSTATUS_RST;
      mcause_q    <= '0;
      mtvec_q     <= MTVEC_RSTV;
      mepc_q      <= '0;
      csr_illegal <= 1'b0;
    end else begin
      csr_illegal <= do_csr & ~writable;
      if (do_trap) begin
        mepc_q                 <= trap_pc & N'(MEPC_WMASK);
        mcause_q               <= trap_cause;
        mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
        mstatus_q[MSTATUS_MIE]  <= 1'b0;
      end else if (do_mret) begin
        mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
        mstatus_q[MSTATUS_MPIE] <= 1'b1;
      end else if (do_csr) begin
        if (hit_mscratch) mscratch_q <= wval_c;
        if (hit_mstatus)  mstatus_q  <= (wval_c & N'(MSTATUS_WMASK)) | N'(MSTATUS_FIXED);
        if (hit_mcause)   mcause_q   <= wval_c;
        if (hit_mtvec)    mtvec_q    <= wval_c & N'(MTVEC_WMASK);
        if (hit_mepc)     mepc_q     <= wval_c & N'(MEPC_WMASK);
      end
    end
  end

`ifdef CSR_CYCLE_EN
  logic [N-1:0] cycle_q;

  // Free-running; ignores stall and wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + N'(1);
  end
`endif

  always_comb begin
    for (int unsigned i = 0; i < W_CSR; i++) csr_out[i] = '0;
    csr_out[IDX_MSCRATCH] = mscratch_q;
    csr_out[IDX_MSTATUS]  = mstatus_q;
    csr_out[IDX_MCAUSE]   = mcause_q;
    csr_out[IDX_MTVEC]    = mtvec_q;
    csr_out[IDX_MEPC]     = mepc_q;
`ifdef CSR_CYCLE_EN
    csr_out[IDX_CYCLE]    = cycle_q;
`else
    csr_out[IDX_CYCLE]    = '0;
`endif
  end

endmodule

// File: tb/tb_csr_regs.sv
// Directed self-checking bench for csr_regs; expected cycle values follow
// whether CSR_CYCLE_EN is defined.
module tb_csr_regs;

  localparam int unsigned  N         = 64;
  localparam int unsigned  W_CSR     = 256;
  localparam logic [N-1:0] MTVEC_RST = 64'h8000_0007;

  logic         clk = 1'b0;
  logic         reset;
  logic         csr_we;
  logic [1:0]   csr_op;
  logic [11:0]  csr_addr;
  logic [N-1:0] csr_wdata;
  logic         trap;
  logic [N-1:0] trap_cause;
  logic [N-1:0] trap_pc;
  logic         mret;
  logic         stall;
  logic [N-1:0] csr_out [0:W_CSR-1];
  logic         csr_illegal;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [63:0]  ncyc    = '0;

  csr_regs #(
    .N         (N),
    .W_CSR     (W_CSR),
    .MTVEC_RST (MTVEC_RST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_we      (csr_we),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .mret        (mret),
    .stall       (stall),
    .csr_out     (csr_out),
    .csr_illegal (csr_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cycle();
`ifdef CSR_CYCLE_EN
    return ncyc;
`else
    return 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    ncyc++;
    #1;
  endtask

  task automatic clear_inputs();
    csr_we = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
    trap = 1'b0; trap_cause = '0; trap_pc = '0; mret = 1'b0; stall = 1'b0;
  endtask

  task automatic csr_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] data);
    csr_we = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = data;
    tick();
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    ncyc  = '0;
    check("cycle_at_release", csr_out[5], 64'd0);

    for (int i = 0; i < 10; i++) tick();
    check("rst_mstatus",  csr_out[1], 64'h1800);
    check("rst_mtvec",    csr_out[3], 64'h8000_0005);
    check("rst_mscratch", csr_out[0], 64'h0);
    check("rst_mcause",   csr_out[2], 64'h0);
    check("rst_mepc",     csr_out[4], 64'h0);
    check("cycle_10",     csr_out[5], exp_cycle());
    check("rst_illegal",  64'(csr_illegal), 64'h0);
    check("unimpl_6",     csr_out[6], 64'h0);
    check("unimpl_255",   csr_out[255], 64'h0);

    // mscratch read-modify-write sequence
    csr_cmd(2'b01, 12'h340, 64'hF0);
    check("mscratch_rw", csr_out[0], 64'hF0);
    csr_cmd(2'b10, 12'h340, 64'h0F);
    check("mscratch_rs", csr_out[0], 64'hFF);
    csr_cmd(2'b11, 12'h340, 64'h3C);
    check("mscratch_rc", csr_out[0], 64'hC3);
    csr_cmd(2'b10, 12'h340, 64'h0);
    check("mscratch_rs0", csr_out[0], 64'hC3);
    check("rs0_no_illegal", 64'(csr_illegal), 64'h0);

    // WARL masks
    csr_cmd(2'b01, 12'h300, '1);
    check("mstatus_warl", csr_out[1], 64'h1888);
    csr_cmd(2'b01, 12'h341, 64'h1003);
    check("mepc_warl", csr_out[4], 64'h1000);
    csr_cmd(2'b01, 12'h305, 64'hFF);
    check("mtvec_warl", csr_out[3], 64'hFD);
    csr_cmd(2'b01, 12'h342, 64'h8000_0000_0000_0001);
    check("mcause_full", csr_out[2], 64'h8000_0000_0000_0001);

    // Trap entry then MRET
    csr_cmd(2'b01, 12'h300, 64'h8);
    check("mstatus_mie", csr_out[1], 64'h1808);
    trap = 1'b1; trap_pc = 64'h2006; trap_cause = 64'd2;
    tick();
    clear_inputs();
    check("trap_mepc",    csr_out[4], 64'h2004);
    check("trap_mcause",  csr_out[2], 64'h2);
    check("trap_mstatus", csr_out[1], 64'h1880);
    mret = 1'b1;
    tick();
    clear_inputs();
    check("mret_mstatus", csr_out[1], 64'h1888);
    check("mret_mepc",    csr_out[4], 64'h2004);

    // Illegal writes
    csr_cmd(2'b01, 12'hC00, 64'h55);
    check("ill_c00_pulse", 64'(csr_illegal), 64'h1);
    check("ill_c00_cycle", csr_out[5], exp_cycle());
    tick();
    check("ill_c00_drop", 64'(csr_illegal), 64'h0);
    csr_cmd(2'b01, 12'h123, 64'h55);
    check("ill_123_pulse", 64'(csr_illegal), 64'h1);
    tick();
    check("ill_123_drop", 64'(csr_illegal), 64'h0);
    csr_cmd(2'b10, 12'h301, 64'h0);
    check("ill_301_rs0", 64'(csr_illegal), 64'h0);
    csr_cmd(2'b01, 12'h301, 64'h1);
    check("ill_301_rw", 64'(csr_illegal), 64'h1);
    csr_cmd(2'b00, 12'h123, 64'h1);
    check("nop_no_illegal", 64'(csr_illegal), 64'h0);

    // trap + mret + write in one cycle: trap only
    trap = 1'b1; trap_cause = 64'hB; trap_pc = 64'h3003; mret = 1'b1;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h342; csr_wdata = 64'h7;
    tick();
    clear_inputs();
    check("prio_mcause",  csr_out[2], 64'hB);
    check("prio_mepc",    csr_out[4], 64'h3000);
    check("prio_mstatus", csr_out[1], 64'h1880);

    // mret beats an illegal write, which is dropped without a pulse
    mret = 1'b1;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h123; csr_wdata = 64'h1;
    tick();
    clear_inputs();
    check("mret_prio_status",  csr_out[1], 64'h1888);
    check("mret_prio_illegal", 64'(csr_illegal), 64'h0);

    // Same triple under stall: nothing but the counter moves
    stall = 1'b1; trap = 1'b1; trap_cause = 64'h5; trap_pc = 64'h4444; mret = 1'b1;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h342; csr_wdata = 64'h7;
    tick();
    clear_inputs();
    check("stall_mcause",  csr_out[2], 64'hB);
    check("stall_mepc",    csr_out[4], 64'h3000);
    check("stall_mstatus", csr_out[1], 64'h1888);
    check("stall_cycle",   csr_out[5], exp_cycle());
    stall = 1'b1;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h123; csr_wdata = 64'h1;
    tick();
    clear_inputs();
    check("stall_illegal", 64'(csr_illegal), 64'h0);

    // Asynchronous reset mid-cycle
    reset = 1'b1;
    #2;
    check("areset_mscratch", csr_out[0], 64'h0);
    check("areset_mstatus",  csr_out[1], 64'h1800);
    check("areset_mcause",   csr_out[2], 64'h0);
    check("areset_mtvec",    csr_out[3], 64'h8000_0005);
    check("areset_cycle",    csr_out[5], 64'h0);
    reset = 1'b0;
    ncyc  = '0;
    tick();
    tick();
    tick();
    check("cycle_after_rerelease", csr_out[5], exp_cycle());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
